// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store initiator: opcodes, FSM states,
// byte-lane masks and the default data-memory window.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  localparam logic [31:0] LSU_BASE_ADDR = 32'h8002_0000;
  localparam int unsigned LSU_MEM_DEPTH = 250000;

  function automatic logic isStore(lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic isMisaligned(lsu_op_e op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Bundles the core request/response handshake and the word-wide data-memory port.
// slave is the initiator's view; master is the core-plus-memory side.
interface lsu_mem_initiator_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  lsu_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_done;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rw;
  logic        mem_en;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_done, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_rw, mem_en
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_done, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_rw, mem_en
  );

endinterface

// File: rtl/lsu_lane_unit.sv
// Big-endian byte-lane logic: extracts and extends load data from a memory word
// and merges sub-word store data into a previously read word.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byteShift;
  logic [4:0]  halfShift;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Offset 0 is the most significant lane, so the shift is (3 - off) lanes.
  always_comb begin
    byteShift = {~off_i, 3'b000};
    halfShift = {~off_i[1], 4'b0000};
    byteVal   = 8'(word_i >> byteShift);
    halfVal   = 16'(word_i >> halfShift);

    load_o = '0;
    case (op_i)
      OP_LB:   load_o = {{24{byteVal[7]}}, byteVal};
      OP_LBU:  load_o = {24'b0, byteVal};
      OP_LH:   load_o = {{16{halfVal[15]}}, halfVal};
      OP_LHU:  load_o = {16'b0, halfVal};
      OP_LW:   load_o = word_i;
      default: load_o = '0;
    endcase

    merged_o = word_i;
    case (op_i)
      OP_SB: merged_o = (word_i & ~(BYTE_LANE_MASK << byteShift))
                      | ((wdata_i & BYTE_LANE_MASK) << byteShift);
      OP_SH: merged_o = (word_i & ~(HALF_LANE_MASK << halfShift))
                      | ((wdata_i & HALF_LANE_MASK) << halfShift);
      OP_SW: merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one byte/half/word request into read, write or
// read-modify-write accesses on a word-wide big-endian data memory port.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = LSU_BASE_ADDR,
  parameter int unsigned MEM_DEPTH = LSU_MEM_DEPTH
) (
  input logic          clock,
  input logic          reset,
  lsu_mem_initiator_if.slave bus
);

  localparam logic [31:0] LAST_WORD_OFF = 32'(MEM_DEPTH - 3);

  lsu_state_e  state_q;
  lsu_op_e     op_q;
  logic [1:0]  byteOff_q;
  logic [31:0] wdata_q;
  logic        respDone_q;
  logic        respErr_q;
  logic [31:0] respRdata_q;
  logic        memEn_q;
  logic        memRw_q;
  logic [31:0] memAddr_q;
  logic [31:0] memWdata_q;

  logic [31:0] alignedAddr;
  logic [31:0] wordOff;
  logic        reqErr;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  // The offset subtraction wraps, so addresses below the base also look out of range.
  always_comb begin
    alignedAddr = {bus.req_addr[31:2], 2'b00};
    wordOff     = alignedAddr - BASE_ADDR;
    reqErr      = isMisaligned(bus.req_op, bus.req_addr[1:0]) || (wordOff > LAST_WORD_OFF);
  end

  lsu_lane_unit laneUnit (
    .op_i    (op_q),
    .off_i   (byteOff_q),
    .word_i  (bus.mem_rdata),
    .wdata_i (wdata_q),
    .load_o  (loadData),
    .merged_o(mergedWord)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LB;
      byteOff_q   <= '0;
      wdata_q     <= '0;
      respDone_q  <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
      memEn_q     <= 1'b0;
      memRw_q     <= 1'b1;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            byteOff_q   <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
            if (reqErr) begin
              state_q    <= ST_DONE;
              respDone_q <= 1'b1;
              respErr_q  <= 1'b1;
            end else if (bus.req_op == OP_SW) begin
              state_q    <= ST_WRITE;
              memAddr_q  <= alignedAddr;
              memRw_q    <= 1'b0;
              memEn_q    <= 1'b1;
              memWdata_q <= bus.req_wdata;
            end else begin
              state_q   <= ST_READ;
              memAddr_q <= alignedAddr;
              memRw_q   <= 1'b1;
              memEn_q   <= 1'b0;
            end
          end
        end
        // Read data is consumed at the end of READ: either as the load result
        // or as the background word for a sub-word store.
        ST_READ: begin
          if (isStore(op_q)) begin
            state_q    <= ST_WRITE;
            memRw_q    <= 1'b0;
            memEn_q    <= 1'b1;
            memWdata_q <= mergedWord;
          end else begin
            state_q     <= ST_DONE;
            respDone_q  <= 1'b1;
            respRdata_q <= loadData;
          end
        end
        ST_WRITE: begin
          state_q    <= ST_DONE;
          memRw_q    <= 1'b1;
          memEn_q    <= 1'b0;
          respDone_q <= 1'b1;
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          respDone_q <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is masked by reset so an abort never lands a partial store.
  assign bus.mem_en     = memEn_q & ~reset;
  assign bus.mem_rw     = memRw_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_done  = respDone_q;
  assign bus.resp_err   = respErr_q;
  assign bus.resp_rdata = respRdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Table-driven bench for the load/store initiator with a small word memory model,
// plus hand-written sequences for reset abort and back-to-back requests.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  typedef struct {
    lsu_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWrites;
    logic [31:0] expWdata;
    logic [31:0] expWaddr;
  } vec_t;

  localparam int NUM_VECS = 22;

  logic clock;
  logic reset;
  logic memClear;
  logic [31:0] memArray [64];
  int checkCount;
  int errorCount;
  vec_t vecs [NUM_VECS];

  lsu_mem_initiator_if busIf ();

  lsu_mem_initiator #(
    .BASE_ADDR(32'h8002_0000),
    .MEM_DEPTH(250000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (busIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word memory model: combinational read, write on posedge when en=1 and rw=0.
  assign busIf.mem_rdata = memArray[busIf.mem_addr[7:2]];
  always @(posedge clock) begin
    if (memClear) begin
      for (int i = 0; i < 64; i++) memArray[i] <= '0;
    end else if (busIf.mem_en && !busIf.mem_rw) begin
      memArray[busIf.mem_addr[7:2]] <= busIf.mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    int writes;
    int enCycles;
    int readyHigh;
    logic [31:0] wrData;
    logic [31:0] wrAddr;
    logic [31:0] gotData;
    logic        gotErr;
    lat = 0; writes = 0; enCycles = 0; readyHigh = 0;
    wrData = '0; wrAddr = '0; gotData = '0; gotErr = 1'b0;
    @(negedge clock);
    checkOutput({tag, " ready_idle"}, 32'(busIf.req_ready), 32'd1);
    busIf.req_valid = 1'b1;
    busIf.req_op    = v.op;
    busIf.req_addr  = v.addr;
    busIf.req_wdata = v.wdata;
    @(posedge clock);
    #1 busIf.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
      @(negedge clock);
      if (busIf.req_ready) readyHigh++;
      if (busIf.mem_en) enCycles++;
      if (busIf.mem_en && !busIf.mem_rw) begin
        writes++;
        wrData = busIf.mem_wdata;
        wrAddr = busIf.mem_addr;
      end
      if (busIf.resp_done) begin
        lat     = cyc;
        gotData = busIf.resp_rdata;
        gotErr  = busIf.resp_err;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, " rdata"}, gotData, v.expRdata);
    checkOutput({tag, " err"}, 32'(gotErr), 32'(v.expErr));
    checkOutput({tag, " writes"}, 32'(writes), 32'(v.expWrites));
    checkOutput({tag, " en_cycles"}, 32'(enCycles), 32'(v.expWrites));
    checkOutput({tag, " ready_busy"}, 32'(readyHigh), 32'd0);
    if (v.expWrites > 0) begin
      checkOutput({tag, " wr_data"}, wrData, v.expWdata);
      checkOutput({tag, " wr_addr"}, wrAddr, v.expWaddr);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;

    //           op      addr          wdata         rdata         err lat wr wdata         waddr
    vecs[0]  = '{OP_SW,  32'h8002_0000, 32'hDEAD_BEEF, 32'h0000_0000, 0, 2, 1, 32'hDEAD_BEEF, 32'h8002_0000};
    vecs[1]  = '{OP_LW,  32'h8002_0000, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 32'h0,         32'h0};
    vecs[2]  = '{OP_LB,  32'h8002_0001, 32'h0,         32'hFFFF_FFAD, 0, 2, 0, 32'h0,         32'h0};
    vecs[3]  = '{OP_LBU, 32'h8002_0001, 32'h0,         32'h0000_00AD, 0, 2, 0, 32'h0,         32'h0};
    vecs[4]  = '{OP_LHU, 32'h8002_0002, 32'h0,         32'h0000_BEEF, 0, 2, 0, 32'h0,         32'h0};
    vecs[5]  = '{OP_LH,  32'h8002_0002, 32'h0,         32'hFFFF_BEEF, 0, 2, 0, 32'h0,         32'h0};
    vecs[6]  = '{OP_SB,  32'h8002_0002, 32'hABCD_EF11, 32'h0000_0000, 0, 3, 1, 32'hDEAD_11EF, 32'h8002_0000};
    vecs[7]  = '{OP_SH,  32'h8002_0000, 32'hFFFF_1234, 32'h0000_0000, 0, 3, 1, 32'h1234_11EF, 32'h8002_0000};
    vecs[8]  = '{OP_LW,  32'h8002_0000, 32'h0,         32'h1234_11EF, 0, 2, 0, 32'h0,         32'h0};
    vecs[9]  = '{OP_LB,  32'h8002_0003, 32'h0,         32'hFFFF_FFEF, 0, 2, 0, 32'h0,         32'h0};
    vecs[10] = '{OP_LB,  32'h8002_0000, 32'h0,         32'h0000_0012, 0, 2, 0, 32'h0,         32'h0};
    vecs[11] = '{OP_LH,  32'h8002_0000, 32'h0,         32'h0000_1234, 0, 2, 0, 32'h0,         32'h0};
    vecs[12] = '{OP_LH,  32'h8002_0001, 32'h0,         32'h0000_0000, 1, 1, 0, 32'h0,         32'h0};
    vecs[13] = '{OP_SW,  32'h8002_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 0, 32'h0,         32'h0};
    vecs[14] = '{OP_LW,  32'h8001_FFFC, 32'h0,         32'h0000_0000, 1, 1, 0, 32'h0,         32'h0};
    vecs[15] = '{OP_LW,  32'h8005_D08E, 32'h0,         32'h0000_0000, 1, 1, 0, 32'h0,         32'h0};
    vecs[16] = '{OP_SB,  32'h8005_D090, 32'h0000_0055, 32'h0000_0000, 1, 1, 0, 32'h0,         32'h0};
    vecs[17] = '{OP_SW,  32'h8005_D08C, 32'hA5A5_A5A5, 32'h0000_0000, 0, 2, 1, 32'hA5A5_A5A5, 32'h8005_D08C};
    vecs[18] = '{OP_LBU, 32'h8005_D08F, 32'h0,         32'h0000_00A5, 0, 2, 0, 32'h0,         32'h0};
    vecs[19] = '{OP_SH,  32'h8005_D08E, 32'h0000_BEEF, 32'h0000_0000, 0, 3, 1, 32'hA5A5_BEEF, 32'h8005_D08C};
    vecs[20] = '{OP_LH,  32'h8005_D08E, 32'h0,         32'hFFFF_BEEF, 0, 2, 0, 32'h0,         32'h0};
    vecs[21] = '{OP_LB,  32'h8005_D08C, 32'h0,         32'hFFFF_FFA5, 0, 2, 0, 32'h0,         32'h0};

    reset           = 1'b1;
    memClear        = 1'b1;
    busIf.req_valid = 1'b0;
    busIf.req_op    = OP_LB;
    busIf.req_addr  = '0;
    busIf.req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("reset done", 32'(busIf.resp_done), 32'd0);
    checkOutput("reset err", 32'(busIf.resp_err), 32'd0);
    checkOutput("reset rdata", busIf.resp_rdata, 32'h0);
    checkOutput("reset mem_en", 32'(busIf.mem_en), 32'd0);
    checkOutput("reset mem_rw", 32'(busIf.mem_rw), 32'd1);
    checkOutput("reset mem_addr", busIf.mem_addr, 32'h0);
    checkOutput("reset mem_wdata", busIf.mem_wdata, 32'h0);
    reset    = 1'b0;
    memClear = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the WRITE cycle of an SB must abort without touching memory.
    @(negedge clock);
    checkOutput("abort ready", 32'(busIf.req_ready), 32'd1);
    busIf.req_valid = 1'b1;
    busIf.req_op    = OP_SB;
    busIf.req_addr  = 32'h8002_0001;
    busIf.req_wdata = 32'h0000_0077;
    @(posedge clock);
    #1 busIf.req_valid = 1'b0;
    @(negedge clock);
    checkOutput("abort read rw", 32'(busIf.mem_rw), 32'd1);
    checkOutput("abort read en", 32'(busIf.mem_en), 32'd0);
    checkOutput("abort read addr", busIf.mem_addr, 32'h8002_0000);
    @(negedge clock);
    checkOutput("abort write en", 32'(busIf.mem_en), 32'd1);
    checkOutput("abort write data", busIf.mem_wdata, 32'h1277_11EF);
    reset = 1'b1;
    #1;
    checkOutput("abort gated en", 32'(busIf.mem_en), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort mem_addr", busIf.mem_addr, 32'h0);
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("abort done%0d", n), 32'(busIf.resp_done), 32'd0);
      checkOutput($sformatf("abort ready%0d", n), 32'(busIf.req_ready), 32'd1);
      @(negedge clock);
    end
    checkOutput("abort mem word", memArray[0], 32'h1234_11EF);
    applyStimulus('{OP_LW, 32'h8002_0000, 32'h0, 32'h1234_11EF, 0, 2, 0, 32'h0, 32'h0}, "abort_lw");

    // Four back-to-back LW with req_valid held: accept every third cycle.
    @(negedge clock);
    busIf.req_valid = 1'b1;
    busIf.req_op    = OP_LW;
    busIf.req_addr  = 32'h8002_0000;
    busIf.req_wdata = '0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clock);
      checkOutput($sformatf("b2b ready%0d", n), 32'(busIf.req_ready), 32'((n % 3) == 0));
      checkOutput($sformatf("b2b done%0d", n), 32'(busIf.resp_done), 32'((n % 3) == 2));
      if ((n % 3) == 2) begin
        checkOutput($sformatf("b2b rdata%0d", n), busIf.resp_rdata, 32'h1234_11EF);
      end
    end
    @(negedge clock);
    busIf.req_valid = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
